// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling on a clock divider,
// one-entry valid/ready holding register with parity, framing and overrun status.
module uart_rx #(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int ParityBits   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_in,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy,
  output logic [2:0]          state_dbg
);

  if (ClockDivider < 4) begin : g_bad_divider
    $error("uart_rx: ClockDivider must be >= 4");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_rx: DataBits must be in [5,9]");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
    $error("uart_rx: StopBits must be 1 or 2");
  end
  if (ParityBits != 0 && ParityBits != 1) begin : g_bad_parity_bits
    $error("uart_rx: ParityBits must be 0 or 1");
  end

  localparam int CntW = $clog2(ClockDivider);
  localparam logic [CntW-1:0] CntLast  = CntW'(ClockDivider - 1);
  localparam logic [CntW-1:0] CntMid   = CntW'(ClockDivider / 2 - 1);
  localparam logic [3:0]      DataLast = 4'(DataBits - 1);
  localparam logic [3:0]      StopLast = 4'(StopBits - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    DELIVER = 3'd5
  } state_t;

  state_t              state;
  logic                sync1;
  logic                rx_s;
  logic                rx_prev;
  logic [1:0]          settle;
  logic [CntW-1:0]     cnt;
  logic [3:0]          idx;
  logic [DataBits-1:0] shift;
  logic                par_bad;
  logic                stop_bad;
  logic                start_edge;
  logic                sample_tick;

  assign state_dbg   = state;
  assign start_edge  = rx_prev & ~rx_s;
  assign sample_tick = (cnt == CntLast);

  // rx_prev is held low until the synchroniser has flushed its reset ones, so a
  // line that is already low when reset releases never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
      settle  <= 2'd0;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= (settle == 2'd2) ? rx_s : 1'b0;
      if (settle != 2'd2) settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      par_bad        <= 1'b0;
      stop_bad       <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;

      if (state != IDLE) cnt <= sample_tick ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (start_edge) begin
            state    <= START;
            busy     <= 1'b1;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
        end
        START: begin
          if (cnt == CntMid) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            shift <= {rx_s, shift[DataBits-1:1]};
            if (idx == DataLast) begin
              idx   <= '0;
              state <= (ParityBits != 0) ? PARITY : STOP;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (sample_tick) begin
            par_bad <= (rx_s != ^shift);
            state   <= STOP;
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (!rx_s) stop_bad <= 1'b1;
            if (idx == StopLast) begin
              idx   <= '0;
              state <= DELIVER;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        DELIVER: begin
          // A consumer taking the held word this same cycle frees the slot.
          if (!data_out_valid || data_out_ready) begin
            data_out       <= shift;
            parity_err     <= par_bad;
            frame_err      <= stop_bad;
            data_out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a frame-level reference
// model; two instances cover the no-parity and even-parity frame formats.
module tb_uart_rx;

  localparam int CD = 8;
  localparam int DB = 8;
  localparam int W  = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rdy0 = 1'b1;
  logic rdy1 = 1'b1;
  logic [DB-1:0] dout0, dout1;
  logic vld0, vld1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  uart_rx #(.ClockDivider(CD), .DataBits(DB), .StopBits(1), .ParityBits(0)) u_dut (
    .clk(clk), .rst(rst), .rx_in(rx0),
    .data_out(dout0), .data_out_valid(vld0), .data_out_ready(rdy0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0),
    .state_dbg(st0)
  );

  uart_rx #(.ClockDivider(CD), .DataBits(DB), .StopBits(1), .ParityBits(1)) u_dut_p (
    .clk(clk), .rst(rst), .rx_in(rx1),
    .data_out(dout1), .data_out_valid(vld1), .data_out_ready(rdy1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1),
    .state_dbg(st1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries are {frame_err, parity_err, data}.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got0_q[$];
  logic [W-1:0] got1_q[$];
  int ovr0_n = 0, ovr1_n = 0, vcnt0 = 0, busy0_n = 0, rise0 = 0;
  logic vld0_d = 1'b0;

  always @(negedge clk) begin
    if (vld0 && rdy0) got0_q.push_back({ferr0, perr0, dout0});
    if (vld1 && rdy1) got1_q.push_back({ferr1, perr1, dout1});
    if (ovr0) ovr0_n++;
    if (ovr1) ovr1_n++;
    if (vld0) vcnt0++;
    if (busy0) busy0_n++;
    if (vld0 && !vld0_d) rise0 = cyc;
    vld0_d = vld0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model of the expected entry: parity error is any disagreement
  // between the sent parity bit and the even parity of the data.
  function automatic logic [W-1:0] model(input logic [DB-1:0] d, input logic has_par,
                                         input logic par, input logic stop);
    logic pe;
    pe = has_par ? (par != ^d) : 1'b0;
    return {~stop, pe, d};
  endfunction

  task automatic send0(input logic [DB-1:0] d, input logic stop, input logic after,
                       input int gap, output int fall);
    rx0 = 1'b0;
    fall = cyc;
    tick(CD);
    for (int i = 0; i < DB; i++) begin
      rx0 = d[i];
      tick(CD);
    end
    rx0 = stop;
    tick(CD);
    rx0 = after;
    tick(gap);
  endtask

  task automatic send1(input logic [DB-1:0] d, input logic par, input logic stop, input int gap);
    rx1 = 1'b0;
    tick(CD);
    for (int i = 0; i < DB; i++) begin
      rx1 = d[i];
      tick(CD);
    end
    rx1 = par;
    tick(CD);
    rx1 = stop;
    tick(CD);
    rx1 = 1'b1;
    tick(gap);
  endtask

  task automatic wait_got(input int which, input int n, input int budget);
    int k;
    k = 0;
    while (((which == 0) ? got0_q.size() : got1_q.size()) < n && k < budget) begin
      tick(1);
      k++;
    end
    chk($sformatf("frames_seen_%0d", which),
        32'((which == 0) ? got0_q.size() : got1_q.size()), 32'(n));
  endtask

  task automatic pop_chk(input int which, input string tag, input logic [W-1:0] exp);
    logic [W-1:0] g;
    if (((which == 0) ? got0_q.size() : got1_q.size()) == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      g = (which == 0) ? got0_q.pop_front() : got1_q.pop_front();
      chk(tag, 32'(g), 32'(exp));
    end
  endtask

  initial begin
    int fall, lat, o, v, b, n;
    logic [DB-1:0] d;
    logic pbad, sbad, par;
    int gap;

    // Reset state
    tick(3);
    chk("rst_data", 32'(dout0), 32'd0);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_flags", 32'({perr0, ferr0, ovr0, busy0}), 32'd0);
    chk("rst_flags_p", 32'({vld1, perr1, ferr1, ovr1, busy1}), 32'd0);
    rst = 1'b0;
    tick(4);

    // 1: single frame, ready high
    v = vcnt0;
    o = ovr0_n;
    send0(8'hA5, 1'b1, 1'b1, 0, fall);
    wait_got(0, 1, 4 * CD);
    pop_chk(0, "t1_frame", model(8'hA5, 1'b0, 1'b0, 1'b1));
    chk("t1_valid_cycles", 32'(vcnt0 - v), 32'd1);
    chk("t1_no_overrun", 32'(ovr0_n - o), 32'd0);
    lat = rise0 - fall;
    chk("t1_latency", 32'(lat >= (10 * CD - CD / 2 + 3) - 2 && lat <= (10 * CD - CD / 2 + 3) + 2), 32'd1);

    // 2: back-to-back with consumer stalled, then released
    rdy0 = 1'b0;
    o = ovr0_n;
    send0(8'h3C, 1'b1, 1'b1, 0, fall);
    send0(8'hC3, 1'b1, 1'b1, 2, fall);
    chk("t2_valid_held", 32'(vld0), 32'd1);
    chk("t2_data_held", 32'(dout0), 32'h3C);
    chk("t2_overrun_once", 32'(ovr0_n - o), 32'd1);
    rdy0 = 1'b1;
    wait_got(0, 1, 4);
    pop_chk(0, "t2_consumed", model(8'h3C, 1'b0, 1'b0, 1'b1));
    chk("t2_valid_drop", 32'(vld0), 32'd0);

    // 4: stop bit low, then line held low for 20 bit times
    send0(8'h55, 1'b0, 1'b0, 20 * CD, fall);
    wait_got(0, 1, 1);
    pop_chk(0, "t4_frame_err", model(8'h55, 1'b0, 1'b0, 1'b0));
    chk("t4_idle_low_busy", 32'(busy0), 32'd0);
    rx0 = 1'b1;
    tick(2 * CD);
    chk("t4_no_more_frames", 32'(got0_q.size()), 32'd0);

    // 5: short low glitch is a false start
    b = busy0_n;
    v = vcnt0;
    rx0 = 1'b0;
    tick(3);
    rx0 = 1'b1;
    tick(3 * CD);
    chk("t5_busy_seen", 32'(busy0_n > b), 32'd1);
    chk("t5_busy_back", 32'(busy0), 32'd0);
    chk("t5_no_valid", 32'(vcnt0 - v), 32'd0);

    // 3: even parity instance
    send1(8'h07, 1'b1, 1'b1, CD);
    wait_got(1, 1, 4 * CD);
    pop_chk(1, "t3_parity_ok", model(8'h07, 1'b1, 1'b1, 1'b1));
    send1(8'h07, 1'b0, 1'b1, CD);
    wait_got(1, 1, 4 * CD);
    pop_chk(1, "t3_parity_bad", model(8'h07, 1'b1, 1'b0, 1'b1));

    // 6: reset during the 4th data bit; line left low across reset release
    v = vcnt0;
    rx0 = 1'b0;
    tick(CD);
    rx0 = 1'b1;
    tick(3 * CD);
    rx0 = 1'b0;
    tick(CD / 2);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_data", 32'(dout0), 32'd0);
    chk("t6_rst_flags", 32'({vld0, perr0, ferr0, ovr0, busy0}), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3 * CD);
    chk("t6_low_after_rst", 32'({busy0, vld0}), 32'd0);
    chk("t6_no_frame", 32'(vcnt0 - v), 32'd0);
    rx0 = 1'b1;
    tick(CD);
    send0(8'h81, 1'b1, 1'b1, 0, fall);
    wait_got(0, 1, 4 * CD);
    pop_chk(0, "t6_clean_frame", model(8'h81, 1'b0, 1'b0, 1'b1));

    // Randomized frames, no parity, gaps down to zero
    o = ovr0_n;
    n = 10;
    for (int i = 0; i < n; i++) begin
      d = DB'($urandom_range(0, 255));
      exp_q.push_back(model(d, 1'b0, 1'b0, 1'b1));
      send0(d, 1'b1, 1'b1, $urandom_range(0, 2 * CD), fall);
    end
    wait_got(0, n, 4 * CD);
    for (int i = 0; i < n; i++) pop_chk(0, $sformatf("rnd0_%0d", i), exp_q.pop_front());
    chk("rnd0_no_overrun", 32'(ovr0_n - o), 32'd0);

    // Randomized frames with parity and stop-bit corruption
    o = ovr1_n;
    n = 12;
    for (int i = 0; i < n; i++) begin
      d = DB'($urandom_range(0, 255));
      pbad = ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 3) == 0);
      par = (^d) ^ pbad;
      gap = sbad ? $urandom_range(2, 2 * CD) : $urandom_range(0, 2 * CD);
      exp_q.push_back(model(d, 1'b1, par, ~sbad));
      send1(d, par, ~sbad, gap);
    end
    wait_got(1, n, 4 * CD);
    for (int i = 0; i < n; i++) pop_chk(1, $sformatf("rnd1_%0d", i), exp_q.pop_front());
    chk("rnd1_no_overrun", 32'(ovr1_n - o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
